// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, start + DATA_W data bits (LSB first) + optional parity + 1/2 stop bits.
module uart_tx #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIV_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_data_valid,
   output logic              tx_data_ready,
   output logic              tx,
   output logic              tx_busy,
   output logic              tx_done,
   input  logic [DIV_W-1:0]  csr_baud_div,
   input  logic              csr_parity_en,
   input  logic              csr_parity_odd,
   input  logic              csr_stop2
);

   localparam int unsigned BIT_W = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    baud_cnt_q, baud_cnt_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                par_en_q, par_en_d;
   logic                stop2_q, stop2_d;
   logic                parity_q, parity_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [DIV_W-1:0]    div_m1;
   logic                bit_end;
   logic                last_data_bit;

   // Ready is combinational from state so a byte can be taken in the done cycle.
   assign tx_data_ready = (state_q == ST_IDLE) && !rst;
   assign tx            = tx_q;
   assign tx_busy       = busy_q;
   assign tx_done       = done_q;

   // Bit-period terminal count; a zero divisor behaves as one.
   always_comb begin
      div_m1        = (div_q == '0) ? '0 : div_q - DIV_W'(1);
      bit_end       = (baud_cnt_q == div_m1);
      last_data_bit = (bit_cnt_q == BIT_W'(DATA_W - 1));
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      div_d      = div_q;
      par_en_d   = par_en_q;
      stop2_d    = stop2_q;
      parity_d   = parity_q;
      done_d     = 1'b0;
      tx_d       = 1'b1;
      busy_d     = 1'b0;

      if (state_q != ST_IDLE) begin
         baud_cnt_d = bit_end ? '0 : baud_cnt_q + DIV_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            if (tx_data_valid && tx_data_ready) begin
               shift_d  = tx_data;
               div_d    = csr_baud_div;
               par_en_d = csr_parity_en;
               stop2_d  = csr_stop2;
               parity_d = (^tx_data) ^ csr_parity_odd;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (last_data_bit) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            // bit_cnt doubles as the stop-bit index here.
            if (bit_end) begin
               if (stop2_q && (bit_cnt_q == '0)) begin
                  bit_cnt_d = BIT_W'(1);
               end else begin
                  bit_cnt_d = '0;
                  state_d   = ST_IDLE;
                  done_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Line level follows the state being entered so tx stays aligned with state_q.
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = parity_d;
         default:   tx_d = 1'b1;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         div_q      <= '0;
         par_en_q   <= 1'b0;
         stop2_q    <= 1'b0;
         parity_q   <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         div_q      <= div_d;
         par_en_q   <= par_en_d;
         stop2_q    <= stop2_d;
         parity_q   <= parity_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

endmodule
